// File: rtl/hash_mem_responder.sv
// Memory-side responder for the hash core bus: host-preloaded word SRAM, core read/write
// arbitration with window checking, and the start/done/timeout run sequencer.
module hash_mem_responder #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned OUT_WORDS = 16,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    input  logic        host_go,
    input  logic [15:0] output_addr,
    output logic        core_start,
    input  logic        core_done,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        busy,
    output logic        result_valid,
    output logic [4:0]  wr_count,
    output logic        addr_err,
    output logic        timeout
);

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 16;
    localparam int unsigned CW  = 5;
    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_RUN,
        S_COMPLETE
    } state_t;

    state_t          state;
    logic [DW-1:0]   mem_array [DEPTH];
    logic [AW-1:0]   win_base;
    logic [WDW-1:0]  wdog;

    logic            host_in_range;
    logic            core_in_range;
    logic            win_hit;
    logic            core_wr_ok;
    logic            core_bad;
    logic            wr_full;
    logic            wr_inc;
    logic            wd_expired;
    logic [IW-1:0]   host_idx;
    logic [IW-1:0]   core_idx;

    // Address decode; window bounds use 17 bits so a base near 16'hFFFF cannot wrap.
    always_comb begin
        host_in_range = ({1'b0, host_addr} < 17'(DEPTH));
        core_in_range = ({1'b0, mem_addr} < 17'(DEPTH));
        win_hit       = ({1'b0, mem_addr} >= {1'b0, win_base}) &&
                        ({1'b0, mem_addr} < ({1'b0, win_base} + 17'(OUT_WORDS)));
        core_wr_ok    = busy && mem_we && core_in_range && win_hit;
        core_bad      = busy && (!core_in_range || (mem_we && !win_hit));
        wr_full       = (wr_count == CW'(OUT_WORDS));
        wr_inc        = core_wr_ok && !wr_full;
        wd_expired    = (wdog == WDW'(TIMEOUT - 1));
        host_idx      = host_addr[IW-1:0];
        core_idx      = mem_addr[IW-1:0];
    end

    // Storage array: not reset, and no write lands on a reset edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (core_wr_ok) begin
                mem_array[core_idx] <= mem_write_data;
            end else if (!busy && host_we && host_in_range) begin
                mem_array[host_idx] <= host_wdata;
            end
        end
    end

    // Run sequencer, read ports and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            core_start    <= 1'b0;
            busy          <= 1'b0;
            result_valid  <= 1'b0;
            wr_count      <= '0;
            addr_err      <= 1'b0;
            timeout       <= 1'b0;
            host_rdata    <= '0;
            mem_read_data <= '0;
            win_base      <= '0;
            wdog          <= '0;
        end else begin
            core_start    <= 1'b0;
            host_rdata    <= (!busy && host_in_range) ? mem_array[host_idx] : '0;
            mem_read_data <= (busy && core_in_range) ? mem_array[core_idx] : '0;
            if (wr_inc) begin
                wr_count <= wr_count + CW'(1);
            end
            if (core_bad || (core_wr_ok && wr_full)) begin
                addr_err <= 1'b1;
            end

            case (state)
                S_IDLE, S_COMPLETE: begin
                    if (host_go) begin
                        state        <= S_START;
                        core_start   <= 1'b1;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                        win_base     <= output_addr;
                        wr_count     <= '0;
                        addr_err     <= 1'b0;
                        timeout      <= 1'b0;
                        wdog         <= '0;
                    end
                end
                S_START: begin
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (wd_expired) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        wdog <= wdog + WDW'(1);
                        if (!core_done) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (core_done) begin
                        state        <= S_COMPLETE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        if ((wr_count + CW'(wr_inc)) != CW'(OUT_WORDS)) begin
                            addr_err <= 1'b1;
                        end
                    end else if (wd_expired) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        wdog <= wdog + WDW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_mem_responder.sv
// Directed bench for hash_mem_responder: host preload/readback, core runs, bus errors,
// watchdog abort and mid-run reset, with read data checked against a scoreboard queue.
module tb_hash_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_go;
    logic [15:0] output_addr;
    logic        core_start;
    logic        core_done;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        busy;
    logic        result_valid;
    logic [4:0]  wr_count;
    logic        addr_err;
    logic        timeout;

    int          n_total = 0;
    int          n_bad   = 0;
    int          start_cnt = 0;
    logic [31:0] model [256];
    logic [31:0] exp_q [$];

    hash_mem_responder #(
        .DEPTH     (256),
        .OUT_WORDS (16),
        .TIMEOUT   (100)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rdata     (host_rdata),
        .host_go        (host_go),
        .output_addr    (output_addr),
        .core_start     (core_start),
        .core_done      (core_done),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .busy           (busy),
        .result_valid   (result_valid),
        .wr_count       (wr_count),
        .addr_err       (addr_err),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_start"}, 32'(core_start), 32'd0);
        check({tag, "_rvalid"}, 32'(result_valid), 32'd0);
        check({tag, "_wrcnt"}, 32'(wr_count), 32'd0);
        check({tag, "_aerr"}, 32'(addr_err), 32'd0);
        check({tag, "_tmo"}, 32'(timeout), 32'd0);
        check({tag, "_hrd"}, host_rdata, 32'd0);
        check({tag, "_mrd"}, mem_read_data, 32'd0);
    endtask

    task automatic host_read_range(input string tag, input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            host_addr = 16'(a);
            exp_q.push_back(model[a]);
            tick();
            check(tag, host_rdata, exp_q.pop_front());
        end
    endtask

    task automatic go(input logic [15:0] base);
        output_addr = base;
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
    endtask

    initial begin
        int s0;
        int cnt;
        reset = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_go = 1'b0;
        output_addr = '0; core_done = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_write_data = '0;
        repeat (3) tick();
        check_zero_outputs("reset");
        reset = 1'b0;

        // Preload header words plus known filler above them.
        for (int k = 0; k < 80; k++) begin
            host_we = 1'b1;
            host_addr = 16'(k);
            host_wdata = (k < 20) ? (32'hA000_0000 + 32'(k)) : (32'hC000_0000 + 32'(k));
            model[k] = host_wdata;
            tick();
        end
        host_we = 1'b0;
        host_read_range("host_readback", 0, 19);

        // Core access while idle is ignored.
        mem_we = 1'b1; mem_addr = 16'd5; mem_write_data = 32'hFFFF_FFFF;
        tick();
        mem_we = 1'b0; mem_addr = '0;
        check("idle_core_rd", mem_read_data, 32'd0);
        check("idle_core_aerr", 32'(addr_err), 32'd0);
        host_read_range("idle_core_nowr", 5, 5);

        // Normal run: read header, write 16 results at 32.
        s0 = start_cnt;
        go(16'd32);
        check("run_start_pulse", 32'(core_start), 32'd1);
        check("run_busy", 32'(busy), 32'd1);
        core_done = 1'b0;
        host_we = 1'b1; host_addr = 16'd1; host_wdata = 32'hBAD0_0001;
        tick();
        host_we = 1'b0;
        check("run_start_low", 32'(core_start), 32'd0);
        check("busy_host_rd", host_rdata, 32'd0);
        tick();
        for (int k = 0; k < 20; k++) begin
            mem_addr = 16'(k);
            exp_q.push_back(model[k]);
            tick();
            check("core_rd", mem_read_data, exp_q.pop_front());
        end
        for (int i = 0; i < 16; i++) begin
            mem_we = 1'b1;
            mem_addr = 16'(32 + i);
            mem_write_data = 32'h5000_0000 + 32'(i);
            model[32 + i] = mem_write_data;
            tick();
        end
        mem_we = 1'b0; mem_addr = '0;
        check("run_wrcnt_mid", 32'(wr_count), 32'd16);
        core_done = 1'b1;
        tick();
        check("run_rvalid", 32'(result_valid), 32'd1);
        check("run_busy_low", 32'(busy), 32'd0);
        check("run_wrcnt", 32'(wr_count), 32'd16);
        check("run_aerr", 32'(addr_err), 32'd0);
        check("run_start_count", 32'(start_cnt - s0), 32'd1);
        host_read_range("run_results", 32, 47);
        host_read_range("busy_host_nowr", 1, 1);

        // Write just past the window is dropped and flagged.
        go(16'd32);
        check("win_rvalid_clr", 32'(result_valid), 32'd0);
        core_done = 1'b0;
        tick(); tick();
        mem_we = 1'b1; mem_addr = 16'd48; mem_write_data = 32'h1234_5678;
        tick();
        mem_we = 1'b0; mem_addr = '0;
        check("win_aerr", 32'(addr_err), 32'd1);
        check("win_wrcnt", 32'(wr_count), 32'd0);
        core_done = 1'b1;
        tick();
        host_read_range("win_nowr", 48, 48);

        // Read beyond DEPTH returns 0 and flags.
        go(16'd32);
        check("oor_aerr_clr", 32'(addr_err), 32'd0);
        core_done = 1'b0;
        tick(); tick();
        mem_addr = 16'd300;
        tick();
        mem_addr = '0;
        check("oor_rd", mem_read_data, 32'd0);
        check("oor_aerr", 32'(addr_err), 32'd1);
        core_done = 1'b1;
        tick();
        check("oor_rvalid", 32'(result_valid), 32'd1);

        // Core never lowers done: watchdog aborts the run.
        go(16'd32);
        cnt = 1;
        while (busy === 1'b1 && cnt < 300) begin
            tick();
            cnt++;
        end
        check("tmo_cycles_ok", 32'((cnt >= 100) && (cnt <= 104)), 32'd1);
        check("tmo_flag", 32'(timeout), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_rvalid", 32'(result_valid), 32'd0);

        // Reset mid-run after 5 writes.
        go(16'd64);
        core_done = 1'b0;
        tick(); tick();
        check("rst_tmo_clr", 32'(timeout), 32'd0);
        for (int i = 0; i < 5; i++) begin
            mem_we = 1'b1;
            mem_addr = 16'(64 + i);
            mem_write_data = 32'h7000_0000 + 32'(i);
            model[64 + i] = mem_write_data;
            tick();
        end
        mem_we = 1'b0; mem_addr = 16'd400;
        tick();
        check("rst_pre_wrcnt", 32'(wr_count), 32'd5);
        check("rst_pre_aerr", 32'(addr_err), 32'd1);
        mem_we = 1'b1; mem_addr = 16'd69; mem_write_data = 32'hEEEE_EEEE;
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_we = 1'b0; mem_addr = '0; core_done = 1'b1;
        check_zero_outputs("midrun_reset");
        host_read_range("rst_keep", 64, 69);
        go(16'd64);
        check("rst_go_busy", 32'(busy), 32'd1);
        check("rst_go_aerr", 32'(addr_err), 32'd0);
        check("rst_go_tmo", 32'(timeout), 32'd0);
        check("rst_go_wrcnt", 32'(wr_count), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
